regfile_arbiter: RTL and testbench

Sequences and shares the single-port CPU register file between two requesters: port A (microprogram control unit) and port B (debug-mode front end). Each access is a req/ack transaction; the arbiter latches the winning command, drives the register file's address/data/we/oe pins for exactly one cycle, captures read data, then pulses ack. It sits between the requesters and the register file; the register file's display read port is not touched.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/rr_pick_2.sv | 27 ++
 rtl/regfile_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding and requester ids.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;  // microprogram control unit
  localparam logic PORT_B = 1'b1;  // debug-mode front end

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker.
// Ports:
//   req_a_i, req_b_i - request lines
//   last_i           - id of the port served most recently (PORT_A / PORT_B)
//   gnt_o            - one-hot grant, bit 0 = port A, bit 1 = port B; zero when nobody requests
module rr_pick_2
  import regfile_arb_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_a_i && req_b_i) begin
      // On a tie the port that was not served last goes first.
      gnt_o = (last_i == PORT_A) ? 2'b10 : 2'b01;
    end else if (req_a_i) begin
      gnt_o = 2'b01;
    end else if (req_b_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single-port CPU register file between port A (microprogram control unit) and
// port B (debug front end). Each req/ack transaction takes IDLE -> ACCESS -> ACK: the winning
// command is latched in IDLE, drives the register-file pins for exactly the ACCESS cycle (read
// data captured at its end), and the winner's ack pulses during ACK.
// Ports:
//   i_w_clk, i_w_rst           - clock, synchronous active-high reset
//   i_w_{a,b}_req/_we/_address/_wdata - requester commands, held until ack
//   o_w_{a,b}_ack, o_w_{a,b}_rdata    - completion pulse and last read result per port
//   o_w_rf_address/_in/_we/_oe, i_w_rf_out - register-file pins
//   o_w_busy                   - high whenever the FSM is not idle
// Build option: define REGFILE_ARB_FIXED_PRIO_EN to give port B absolute priority on ties
// (no round-robin pointer; port A can starve while B keeps requesting).
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned p_data_width    = 16,
  parameter int unsigned p_address_width = 3
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst,
  input  logic                       i_w_a_req,
  input  logic                       i_w_a_we,
  input  logic [p_address_width-1:0] i_w_a_address,
  input  logic [p_data_width-1:0]    i_w_a_wdata,
  output logic                       o_w_a_ack,
  output logic [p_data_width-1:0]    o_w_a_rdata,
  input  logic                       i_w_b_req,
  input  logic                       i_w_b_we,
  input  logic [p_address_width-1:0] i_w_b_address,
  input  logic [p_data_width-1:0]    i_w_b_wdata,
  output logic                       o_w_b_ack,
  output logic [p_data_width-1:0]    o_w_b_rdata,
  output logic [p_address_width-1:0] o_w_rf_address,
  output logic [p_data_width-1:0]    o_w_rf_in,
  output logic                       o_w_rf_we,
  output logic                       o_w_rf_oe,
  input  logic [p_data_width-1:0]    i_w_rf_out,
  output logic                       o_w_busy
);

  state_e                     state_q, state_d;
  logic                       we_q, we_d;
  logic [p_address_width-1:0] addr_q, addr_d;
  logic [p_data_width-1:0]    wdata_q, wdata_d;
  logic                       win_q, win_d;
  logic [p_data_width-1:0]    rdata_a_q, rdata_a_d;
  logic [p_data_width-1:0]    rdata_b_q, rdata_b_d;
  logic [1:0]                 gnt;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign gnt = i_w_b_req ? 2'b10 : (i_w_a_req ? 2'b01 : 2'b00);
`else
  logic last_q, last_d;

  rr_pick_2 u_pick (
    .req_a_i (i_w_a_req),
    .req_b_i (i_w_b_req),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      last_q <= PORT_B;  // pretend B went last so A wins the first tie
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    win_d          = win_q;
    rdata_a_d      = rdata_a_q;
    rdata_b_d      = rdata_b_q;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    last_d         = last_q;
`endif
    o_w_rf_address = '0;
    o_w_rf_in      = '0;
    o_w_rf_we      = 1'b0;
    o_w_rf_oe      = 1'b0;
    o_w_a_ack      = 1'b0;
    o_w_b_ack      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          win_d   = gnt[1] ? PORT_B : PORT_A;
          we_d    = gnt[1] ? i_w_b_we      : i_w_a_we;
          addr_d  = gnt[1] ? i_w_b_address : i_w_a_address;
          wdata_d = gnt[1] ? i_w_b_wdata   : i_w_a_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        o_w_rf_address = addr_q;
        if (we_q) begin
          // Gated combinationally so a reset landing here never commits the write.
          o_w_rf_we = ~i_w_rst;
          o_w_rf_in = wdata_q;
        end else begin
          o_w_rf_oe = 1'b1;
          if (win_q == PORT_B) begin
            rdata_b_d = i_w_rf_out;
          end else begin
            rdata_a_d = i_w_rf_out;
          end
        end
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        last_d = win_q;
`endif
        state_d = StAck;
      end
      StAck: begin
        o_w_a_ack = (win_q == PORT_A);
        o_w_b_ack = (win_q == PORT_B);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      win_q     <= PORT_A;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      win_q     <= win_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign o_w_a_rdata = rdata_a_q;
  assign o_w_b_rdata = rdata_b_q;
  assign o_w_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a transaction-level reference model.
module tb_regfile_arbiter;
  import regfile_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, rf_address;
  logic [DW-1:0] a_wdata, b_wdata, rdata_a, rdata_b, rf_in, rf_out;
  logic          ack_a, ack_b, rf_we, rf_oe, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(
    .p_data_width    (DW),
    .p_address_width (AW)
  ) dut (
    .i_w_clk        (clk),
    .i_w_rst        (rst),
    .i_w_a_req      (a_req),
    .i_w_a_we       (a_we),
    .i_w_a_address  (a_addr),
    .i_w_a_wdata    (a_wdata),
    .o_w_a_ack      (ack_a),
    .o_w_a_rdata    (rdata_a),
    .i_w_b_req      (b_req),
    .i_w_b_we       (b_we),
    .i_w_b_address  (b_addr),
    .i_w_b_wdata    (b_wdata),
    .o_w_b_ack      (ack_b),
    .o_w_b_rdata    (rdata_b),
    .o_w_rf_address (rf_address),
    .o_w_rf_in      (rf_in),
    .o_w_rf_we      (rf_we),
    .o_w_rf_oe      (rf_oe),
    .i_w_rf_out     (rf_out),
    .o_w_busy       (busy)
  );

  // Register file behind the arbiter: combinational read on oe, write on the clock edge.
  logic [DW-1:0] rf_mem [2**AW];
  assign rf_out = rf_oe ? rf_mem[rf_address] : '0;
  always @(posedge clk) if (rf_we) rf_mem[rf_address] <= rf_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("we_oe_exclusive", 32'(rf_we & rf_oe), 32'd0);
    check("ack_onehot", 32'(ack_a & ack_b), 32'd0);
  end

  task automatic set_port(input logic p, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (p == PORT_B) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_port(PORT_A, 1'b0, 1'b0, '0, '0);
    set_port(PORT_B, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;  // port's rdata after ack (held value for writes)
  } vec_t;

  // One isolated transaction from a single port; caller is at a negedge with the DUT idle.
  task automatic single_txn(input string name, input vec_t v);
    int   cyc = 0, we_cnt = 0, oe_cnt = 0;
    logic got = 1'b0;
    set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (!got && cyc < 8) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (rf_we) begin
        we_cnt++;
        check({name, ".wr_addr"}, 32'(rf_address), 32'(v.addr));
        check({name, ".wr_data"}, 32'(rf_in), 32'(v.wdata));
      end
      if (rf_oe) begin
        oe_cnt++;
        check({name, ".rd_addr"}, 32'(rf_address), 32'(v.addr));
      end
      check({name, ".other_ack"}, 32'((v.port == PORT_B) ? ack_a : ack_b), 32'd0);
      got = (v.port == PORT_B) ? ack_b : ack_a;
    end
    check({name, ".latency"}, 32'(cyc), 32'd2);
    check({name, ".rdata"}, 32'((v.port == PORT_B) ? rdata_b : rdata_a), 32'(v.exp_rdata));
    check({name, ".we_cycles"}, 32'(we_cnt), v.we ? 32'd1 : 32'd0);
    check({name, ".oe_cycles"}, 32'(oe_cnt), v.we ? 32'd0 : 32'd1);
    set_port(v.port, 1'b0, 1'b0, '0, '0);
    @(posedge clk); @(negedge clk);
    check({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[10];

  // Reference model state for the random phase.
  logic [DW-1:0] ref_regs [2**AW];
  logic [DW-1:0] exp_rd [2];
  int            slot;          // 0 free, 1 access cycle, 2 ack cycle
  logic          cur, c_we, last_b;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          act [2];
  logic          r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wd [2];

  initial begin
    int   cyc, t1, t_a, t_b, n, n_acks, last_t, target;
    logic sel;

    vecs[0] = '{PORT_A, 1'b1, 3'd3, 16'h1234, 16'h0000};
    vecs[1] = '{PORT_B, 1'b0, 3'd3, 16'h0000, 16'h1234};
    vecs[2] = '{PORT_B, 1'b1, 3'd5, 16'h5A5A, 16'h1234};
    vecs[3] = '{PORT_A, 1'b0, 3'd5, 16'h0000, 16'h5A5A};
    vecs[4] = '{PORT_A, 1'b1, 3'd7, 16'hFFFF, 16'h5A5A};
    vecs[5] = '{PORT_B, 1'b0, 3'd7, 16'h0000, 16'hFFFF};
    vecs[6] = '{PORT_B, 1'b0, 3'd3, 16'h0000, 16'h1234};
    vecs[7] = '{PORT_B, 1'b1, 3'd1, 16'h0F0F, 16'h1234};
    vecs[8] = '{PORT_A, 1'b1, 3'd0, 16'hC3C3, 16'h5A5A};
    vecs[9] = '{PORT_A, 1'b0, 3'd0, 16'h0000, 16'hC3C3};

    do_reset();
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.acks", 32'({ack_a, ack_b}), 32'd0);
    check("reset.rdata", 32'({rdata_a, rdata_b}), 32'd0);
    check("reset.rf_pins", 32'({rf_we, rf_oe, rf_address, rf_in}), 32'd0);

    for (int i = 0; i < 10; i++) single_txn($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: A writes r1, B reads r1.
    do_reset();
    set_port(PORT_A, 1'b1, 1'b1, 3'd1, 16'hAAAA);
    set_port(PORT_B, 1'b1, 1'b0, 3'd1, 16'h0000);
    cyc = 0; t_a = 0; t_b = 0;
    while ((t_a == 0 || t_b == 0) && cyc < 14) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (ack_a) begin t_a = cyc; set_port(PORT_A, 1'b0, 1'b0, '0, '0); end
      if (ack_b) begin
        t_b = cyc;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("tie.rdata_b", 32'(rdata_b), 32'h0F0F);
`else
        check("tie.rdata_b", 32'(rdata_b), 32'hAAAA);
`endif
        set_port(PORT_B, 1'b0, 1'b0, '0, '0);
      end
    end
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    check("tie.ack_b_time", 32'(t_b), 32'd2);
    check("tie.ack_a_time", 32'(t_a), 32'd5);
`else
    check("tie.ack_a_time", 32'(t_a), 32'd2);
    check("tie.ack_b_time", 32'(t_b), 32'd5);
`endif
    @(posedge clk); @(negedge clk);

    // Both ports saturating with reads of r1.
    set_port(PORT_A, 1'b1, 1'b0, 3'd1, 16'h0000);
    set_port(PORT_B, 1'b1, 1'b0, 3'd1, 16'h0000);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    target = 4;
`else
    target = 8;
`endif
    cyc = 0; n_acks = 0; last_t = 0;
    while (n_acks < target && cyc < 60) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (ack_a || ack_b) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("sat.grant", 32'(ack_b), 32'd1);
`else
        check("sat.grant", 32'(ack_b), 32'(n_acks % 2));
`endif
        check("sat.rdata", 32'(ack_b ? rdata_b : rdata_a), 32'hAAAA);
        if (n_acks > 0) check("sat.spacing", 32'(cyc - last_t), 32'd3);
        last_t = cyc;
        n_acks++;
      end
    end
    check("sat.count", 32'(n_acks), 32'(target));
    set_port(PORT_B, 1'b0, 1'b0, '0, '0);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    // A finally gets in once B lets go.
    cyc = 0; t_a = 0;
    while (t_a == 0 && cyc < 8) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (ack_a) t_a = cyc;
    end
    check("sat.a_after_b", 32'(t_a), 32'd3);
`endif
    set_port(PORT_A, 1'b0, 1'b0, '0, '0);
    @(posedge clk); @(negedge clk);

    // Reset landing in the ACCESS cycle of a B write to r5.
    set_port(PORT_B, 1'b1, 1'b1, 3'd5, 16'hFFFF);
    @(posedge clk); @(negedge clk);
    check("rst.in_access", 32'(rf_we), 32'd1);
    rst = 1'b1;
    set_port(PORT_B, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst.we_gated", 32'(rf_we), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst.outputs", 32'({ack_a, ack_b, busy, rf_we, rf_oe, rf_address}), 32'd0);
    check("rst.rf_in", 32'(rf_in), 32'd0);
    check("rst.rdata", 32'({rdata_a, rdata_b}), 32'd0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst.no_ack", 32'({ack_a, ack_b, busy}), 32'd0);
    end
    single_txn("rst.readback", '{PORT_A, 1'b0, 3'd5, 16'h0000, 16'h5A5A});

    // Port A back-to-back: new command presented on the ack edge.
    set_port(PORT_A, 1'b1, 1'b1, 3'd0, 16'h0001);
    cyc = 0; t1 = 0; n = 0;
    while (n < 2 && cyc < 12) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (ack_a) begin
        n++;
        if (n == 1) begin
          t1 = cyc;
          set_port(PORT_A, 1'b1, 1'b0, 3'd0, 16'h0000);
        end else begin
          check("b2b.gap", 32'(cyc - t1), 32'd3);
          check("b2b.rdata", 32'(rdata_a), 32'h0001);
        end
      end
    end
    check("b2b.first", 32'(t1), 32'd2);
    check("b2b.count", 32'(n), 32'd2);
    set_port(PORT_A, 1'b0, 1'b0, '0, '0);
    @(posedge clk); @(negedge clk);

    // Random traffic against the reference model; preload known register contents first.
    for (int i = 0; i < 2**AW; i++) begin
      ref_regs[i] = 16'(i * 16'h1111);
      single_txn($sformatf("init%0d", i), '{PORT_A, 1'b1, AW'(i), ref_regs[i], 16'h0001});
    end
    do_reset();
    exp_rd[0] = '0; exp_rd[1] = '0;
    slot = 0; last_b = 1'b1; cur = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
    end

    for (int k = 0; k < 600; k++) begin
      check("rnd.busy", 32'(busy), 32'(slot != 0));
      check("rnd.ack_a", 32'(ack_a), 32'(slot == 2 && cur == PORT_A));
      check("rnd.ack_b", 32'(ack_b), 32'(slot == 2 && cur == PORT_B));
      check("rnd.rf_we", 32'(rf_we), 32'(slot == 1 && c_we));
      check("rnd.rf_oe", 32'(rf_oe), 32'(slot == 1 && !c_we));
      check("rnd.rf_address", 32'(rf_address), (slot == 1) ? 32'(c_addr) : 32'd0);
      check("rnd.rf_in", 32'(rf_in), (slot == 1 && c_we) ? 32'(c_wdata) : 32'd0);
      check("rnd.rdata_a", 32'(rdata_a), 32'(exp_rd[0]));
      check("rnd.rdata_b", 32'(rdata_b), 32'(exp_rd[1]));

      // Requesters: hold until ack, then either chain a new command or drop.
      for (int p = 0; p < 2; p++) begin
        if (act[p] && slot == 2 && cur == p[0]) begin
          act[p] = ($urandom_range(1) == 1);
        end else if (!act[p]) begin
          act[p] = ($urandom_range(2) == 0);
        end else begin
          continue;
        end
        r_we[p]   = $urandom_range(1) == 1;
        r_addr[p] = AW'($urandom_range(2**AW - 1));
        r_wd[p]   = DW'($urandom);
        set_port(p[0], act[p], r_we[p], r_addr[p], r_wd[p]);
      end

      // Model: a grant starts only when free; each transaction occupies three cycles.
      if (slot == 0) begin
        if (act[0] || act[1]) begin
          if (act[0] && act[1]) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            sel = 1'b1;
`else
            sel = !last_b;
`endif
          end else begin
            sel = act[1];
          end
          cur = sel; c_we = r_we[sel]; c_addr = r_addr[sel]; c_wdata = r_wd[sel];
          slot = 1;
        end
      end else if (slot == 1) begin
        if (c_we) ref_regs[c_addr] = c_wdata;
        else exp_rd[cur] = ref_regs[c_addr];
        last_b = cur;
        slot = 2;
      end else begin
        slot = 0;
      end
      @(posedge clk); @(negedge clk);
    end

    set_port(PORT_A, 1'b0, 1'b0, '0, '0);
    set_port(PORT_B, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
